ac97_frame_tx: RTL
==================

# ac97_frame_tx

AC'97 serial-link transmitter, the codec-facing end of the sample path that consumes the synthesizer's `sample_out` / `new_sample_generated` pair. It builds 256-bit AC'97 output frames: a slot-0 tag, slot 1/2 register commands, and slot 3/4 PCM carrying the current sample. Each frame is shifted out MSB-first on `sdata_out` with `sync` framing, one bit per `bit_tick`. It emits the one-cycle `new_frame` pulse that paces the whole music-player pipeline at 48 kHz.

## Interface
- `STEREO`, 0: 0 = `sample_in` duplicated into slots 3 and 4; 1 = slot 4 takes `sample_in_r`
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high
- `bit_tick` in 1: one-cycle enable per codec bit period, already synchronized to `clk`
- `sample_in` in 16: left/mono PCM, two's complement
- `sample_in_r` in 16: right PCM; ignored when `STEREO`=0
- `sample_valid` in 1: one-cycle strobe latching `sample_in`/`sample_in_r` into the holding register
- `cmd_valid` in 1: register-write request
- `cmd_addr` in 7: codec register address
- `cmd_data` in 16: register write data
- `cmd_ready` out 1: command slot free; handshake completes when `cmd_valid & cmd_ready`
- `sync` out 1: AC'97 SYNC
- `sdata_out` out 1: AC'97 SDATA_OUT
- `new_frame` out 1: one-cycle pulse at frame start
- `underrun` out 1: sticky; set when a frame starts with no `sample_valid` since the previous frame start

## Operation
- Bit counter `bit_cnt` runs 0..255 and advances only on `bit_tick`; it wraps from 255 to 0.
- Frame start is a `bit_tick` with `bit_cnt`==0. In that cycle:
  - the 256-bit shift register loads from the holding registers;
  - `new_frame` is registered high for the next `clk` cycle only.
- Tag, slot 0 (bits 255..240 of the frame):
  - bit 15 = 1 (frame valid);
  - bit 14 = bit 13 = 1 iff a command is pending;
  - bits 12 and 11 = 1 (slots 3 and 4 valid);
  - remaining tag bits = 0.
- Slot 1, 20 bits:
  - bit 19 = 0 (write);
  - bits 18:12 = `cmd_addr`;
  - rest = 0;
  - the whole slot is 0 when no command is pending.
- Slot 2, 20 bits: `cmd_data` in bits 19:4, 0 below; the whole slot is 0 when no command is pending.
- Slots 3 and 4, 20 bits each: sample in bits 19:4 and 4'b0000 below.
- Slots 5..12 are all zeros.
- Holding sample register:
  - `sample_valid` overwrites it in any cycle; the last write before frame start wins.
  - With no new sample, the previous value repeats and `underrun` sets.
- `sample_valid` in the same cycle as a frame-start tick is captured for the *next* frame; the load uses the pre-update value.
- Command FSM, states IDLE → PENDING → SENT → IDLE:
  - IDLE: `cmd_ready`=1. On handshake, capture addr/data and go to PENDING.
  - PENDING: go to SENT at the next frame start; that frame carries the command.
  - SENT: go to IDLE on the tick where `bit_cnt`==255 (end of the carrying frame).
  - `cmd_ready`=0 in PENDING and SENT, so exactly one frame carries each command.
- `sync`:
  - driven high on ticks emitting frame bits 0..15 (`bit_cnt` 0..15) and low for 16..255;
  - first rises with bit 0, so it leads the slot-0 data by zero bit periods.
- `underrun` clears only on `reset`.

## Timing
- All outputs are registered.
- Reset values: `sync`=0, `sdata_out`=0, `new_frame`=0, `cmd_ready`=1, `underrun`=0, `bit_cnt`=0, holding sample=0, FSM=IDLE.
- `sdata_out` and `sync` update one `clk` cycle after the `bit_tick` that emits the bit. Between ticks they hold.
- `new_frame` is high exactly one `clk` cycle, one cycle after the frame-start tick.
- Frame period is 256 ticks.
- Reset asserted mid-frame:
  - all state clears immediately (asynchronous);
  - the partial frame is abandoned;
  - the first `bit_tick` after deassertion starts a new frame at bit 0.
- A `bit_tick` held high on consecutive cycles is legal; one bit per cycle.

## Structure
- Package `ac97_pkg`:
  - constants `FRAME_BITS`=256, `TAG_BITS`=16, `SLOT_BITS`=20;
  - tag-bit indices `TAG_VALID`=15, `TAG_SLOT1`=14, `TAG_SLOT2`=13, `TAG_PCM_L`=12, `TAG_PCM_R`=11;
  - command FSM state encoding.
- Sub-module `ac97_frame_builder`: combinational assembly of the 256-bit frame from tag, command, and samples.
- Registers use the existing `dffr` flops.

## Test plan
- Reset release, then `bit_tick` every 4 cycles, `sample_valid` with 16'h1234 before frame 0 → first 16 bits on `sdata_out` are 16'h9800. Slot 3 = 20'h12340, slot 4 = 20'h12340. `sync` high for exactly 16 ticks. `new_frame` pulses once.
- Command handshake, addr 7'h02, data 16'h0808 → `cmd_ready` falls. The next frame's tag is 16'hF800, slot 1 = 20'h02000, slot 2 = 20'h08080. The following frame's tag is 16'h9800. `cmd_ready` returns after bit 255.
- No `sample_valid` for one frame → slots 3/4 repeat the previous value and `underrun`=1 stays set until reset.
- `sample_valid` with 16'hAAAA coincident with a frame-start tick → the current frame carries the old sample; the next frame carries 20'hAAAA0.
- Reset asserted at `bit_cnt`=100 → `sync`/`sdata_out` are 0 immediately. After release, the next tick restarts at bit 0 with `sync`=1.
- `STEREO`=1, `sample_in`=16'h7FFF, `sample_in_r`=16'h8000 → slot 3 = 20'h7FFF0, slot 4 = 20'h80000.

Source files
------------

// File: rtl/ac97_pkg.sv
// ---------------------------------------------------------------------------
// ac97_pkg
// Shared constants and types for the AC'97 output-frame transmitter.
//   - Frame geometry: 256-bit frame = 16-bit tag + twelve 20-bit slots.
//   - Tag bit positions (within the 16-bit tag).
//   - Command FSM state encoding.
//   - pcm_slot(): left-justifies a 16-bit sample into a 20-bit slot.
// ---------------------------------------------------------------------------
package ac97_pkg;

    localparam int FRAME_BITS  = 256;
    localparam int TAG_BITS    = 16;
    localparam int SLOT_BITS   = 20;
    localparam int NUM_SLOTS   = 12;
    localparam int SAMPLE_BITS = 16;
    localparam int ADDR_BITS   = 7;
    localparam int CNT_BITS    = $clog2(FRAME_BITS);

    // SYNC covers exactly the tag: frame bits 0..15.
    localparam logic [CNT_BITS-1:0] SYNC_LEN = CNT_BITS'(TAG_BITS);

    localparam int TAG_VALID = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;
    localparam int TAG_PCM_L = 12;
    localparam int TAG_PCM_R = 11;

    typedef enum logic [1:0] {
        CMD_IDLE    = 2'd0,
        CMD_PENDING = 2'd1,
        CMD_SENT    = 2'd2
    } cmd_state_t;

    // 16-bit PCM sits in slot bits 19:4; the low nibble is padding.
    function automatic logic [SLOT_BITS-1:0] pcm_slot(input logic [SAMPLE_BITS-1:0] s);
        return {s, 4'b0000};
    endfunction

endpackage

// File: rtl/ac97_frame_builder.sv
// ---------------------------------------------------------------------------
// ac97_frame_builder
// Combinational assembly of one 256-bit AC'97 output frame.
//   STEREO        : 0 = left sample in slots 3 and 4, 1 = right sample in slot 4
//   i_cmd_pending : a register write rides in this frame (slots 1/2 + tag bits)
//   i_cmd_addr    : codec register address [6:0]
//   i_cmd_data    : codec register write data [15:0]
//   i_sample_l    : left/mono PCM [15:0]
//   i_sample_r    : right PCM [15:0]
//   o_frame       : frame, bit 255 is transmitted first
// ---------------------------------------------------------------------------
module ac97_frame_builder
    import ac97_pkg::*;
#(
    parameter bit STEREO = 1'b0
) (
    input  logic                   i_cmd_pending,
    input  logic [ADDR_BITS-1:0]   i_cmd_addr,
    input  logic [SAMPLE_BITS-1:0] i_cmd_data,
    input  logic [SAMPLE_BITS-1:0] i_sample_l,
    input  logic [SAMPLE_BITS-1:0] i_sample_r,
    output logic [FRAME_BITS-1:0]  o_frame
);

    logic [TAG_BITS-1:0]  w_tag;
    logic [SLOT_BITS-1:0] w_slot [1:NUM_SLOTS];

    always_comb begin
        w_tag            = '0;
        w_tag[TAG_VALID] = 1'b1;
        w_tag[TAG_SLOT1] = i_cmd_pending;
        w_tag[TAG_SLOT2] = i_cmd_pending;
        w_tag[TAG_PCM_L] = 1'b1;
        w_tag[TAG_PCM_R] = 1'b1;
    end

    // Slot 1: bit 19 = 0 selects a write; address in 18:12.
    assign w_slot[1] = i_cmd_pending ? {1'b0, i_cmd_addr, 12'h000} : '0;
    assign w_slot[2] = i_cmd_pending ? {i_cmd_data, 4'h0} : '0;
    assign w_slot[3] = pcm_slot(i_sample_l);
    assign w_slot[4] = STEREO ? pcm_slot(i_sample_r) : pcm_slot(i_sample_l);

    generate
        for (genvar gi = 5; gi <= NUM_SLOTS; gi++) begin : g_unused_slot
            assign w_slot[gi] = '0;
        end
    endgenerate

    assign o_frame[FRAME_BITS-1 -: TAG_BITS] = w_tag;

    // Slot k occupies the k-th 20-bit field below the tag.
    generate
        for (genvar gi = 1; gi <= NUM_SLOTS; gi++) begin : g_place_slot
            localparam int LP_MSB = FRAME_BITS - TAG_BITS - 1 - SLOT_BITS * (gi - 1);
            assign o_frame[LP_MSB -: SLOT_BITS] = w_slot[gi];
        end
    endgenerate

endmodule

// File: rtl/dffr.sv
// ---------------------------------------------------------------------------
// dffr
// Generic enabled register with asynchronous active-high reset to zero.
//   clk  : clock
//   rst  : asynchronous reset, active high
//   i_en : load enable
//   i_d  : data in  [W-1:0]
//   o_q  : data out [W-1:0]
// ---------------------------------------------------------------------------
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ac97_frame_tx.sv
// ---------------------------------------------------------------------------
// ac97_frame_tx
// AC'97 SDATA_OUT transmitter. Builds a 256-bit frame at each frame start
// (bit counter 0 on a bit_tick) and shifts it out MSB-first, one bit per tick.
//   STEREO       : 0 = sample_in in slots 3 and 4, 1 = sample_in_r in slot 4
//   clk          : system clock
//   reset        : asynchronous, active high
//   bit_tick     : one-cycle enable per codec bit period
//   sample_in    : left/mono PCM [15:0]
//   sample_in_r  : right PCM [15:0]
//   sample_valid : strobe writing the sample holding registers
//   cmd_valid    : register-write request
//   cmd_addr     : codec register address [6:0]
//   cmd_data     : codec register write data [15:0]
//   cmd_ready    : command slot free (handshake on cmd_valid & cmd_ready)
//   sync         : AC'97 SYNC, high for frame bits 0..15
//   sdata_out    : AC'97 SDATA_OUT
//   new_frame    : one-cycle pulse the cycle after a frame-start tick
//   underrun     : sticky, a frame started without a fresh sample
// ---------------------------------------------------------------------------
module ac97_frame_tx
    import ac97_pkg::*;
#(
    parameter bit STEREO = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bit_tick,
    input  logic [SAMPLE_BITS-1:0] sample_in,
    input  logic [SAMPLE_BITS-1:0] sample_in_r,
    input  logic                   sample_valid,
    input  logic                   cmd_valid,
    input  logic [ADDR_BITS-1:0]   cmd_addr,
    input  logic [SAMPLE_BITS-1:0] cmd_data,
    output logic                   cmd_ready,
    output logic                   sync,
    output logic                   sdata_out,
    output logic                   new_frame,
    output logic                   underrun
);

    logic [CNT_BITS-1:0]    r_bit_cnt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic                   r_sync;
    logic                   r_sdata;
    logic                   r_new_frame;
    logic                   r_underrun;
    logic                   r_sample_seen;
    logic                   r_cmd_ready;
    cmd_state_t             r_cmd_state;
    cmd_state_t             w_cmd_state_next;

    logic [SAMPLE_BITS-1:0] r_sample_l;
    logic [SAMPLE_BITS-1:0] r_sample_r;
    logic [ADDR_BITS-1:0]   r_cmd_addr;
    logic [SAMPLE_BITS-1:0] r_cmd_data;

    logic                   w_frame_start;
    logic                   w_frame_end;
    logic                   w_cmd_accept;
    logic                   w_cmd_pending;
    logic [FRAME_BITS-1:0]  w_frame;

    assign w_frame_start = bit_tick && (r_bit_cnt == '0);
    assign w_frame_end   = bit_tick && (r_bit_cnt == '1);
    assign w_cmd_accept  = cmd_valid && r_cmd_ready;
    assign w_cmd_pending = (r_cmd_state == CMD_PENDING);

    // Holding registers. A sample_valid coincident with frame start lands
    // here after the shift register has already loaded the old value.
    dffr #(.W(SAMPLE_BITS)) u_sample_l (
        .clk  (clk),
        .rst  (reset),
        .i_en (sample_valid),
        .i_d  (sample_in),
        .o_q  (r_sample_l)
    );

    dffr #(.W(SAMPLE_BITS)) u_sample_r (
        .clk  (clk),
        .rst  (reset),
        .i_en (sample_valid),
        .i_d  (sample_in_r),
        .o_q  (r_sample_r)
    );

    dffr #(.W(ADDR_BITS)) u_cmd_addr (
        .clk  (clk),
        .rst  (reset),
        .i_en (w_cmd_accept),
        .i_d  (cmd_addr),
        .o_q  (r_cmd_addr)
    );

    dffr #(.W(SAMPLE_BITS)) u_cmd_data (
        .clk  (clk),
        .rst  (reset),
        .i_en (w_cmd_accept),
        .i_d  (cmd_data),
        .o_q  (r_cmd_data)
    );

    ac97_frame_builder #(
        .STEREO (STEREO)
    ) u_builder (
        .i_cmd_pending (w_cmd_pending),
        .i_cmd_addr    (r_cmd_addr),
        .i_cmd_data    (r_cmd_data),
        .i_sample_l    (r_sample_l),
        .i_sample_r    (r_sample_r),
        .o_frame       (w_frame)
    );

    // Bit counter wraps 255 -> 0 by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
        end else if (bit_tick) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Serializer. At frame start bit 255 goes straight to the output and the
    // remaining 255 bits are kept pre-shifted, so every later tick just takes
    // the MSB of r_shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_sdata     <= 1'b0;
            r_sync      <= 1'b0;
            r_new_frame <= 1'b0;
        end else begin
            r_new_frame <= w_frame_start;
            if (bit_tick) begin
                r_sync <= (r_bit_cnt < SYNC_LEN);
                if (w_frame_start) begin
                    r_sdata <= w_frame[FRAME_BITS-1];
                    r_shift <= {w_frame[FRAME_BITS-2:0], 1'b0};
                end else begin
                    r_sdata <= r_shift[FRAME_BITS-1];
                    r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    // r_sample_seen tracks "a sample arrived since the last frame start".
    // A strobe in the frame-start cycle counts toward the following frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underrun    <= 1'b0;
            r_sample_seen <= 1'b0;
        end else if (w_frame_start) begin
            if (!r_sample_seen) begin
                r_underrun <= 1'b1;
            end
            r_sample_seen <= sample_valid;
        end else if (sample_valid) begin
            r_sample_seen <= 1'b1;
        end
    end

    // Command FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_state <= CMD_IDLE;
            r_cmd_ready <= 1'b1;
        end else begin
            r_cmd_state <= w_cmd_state_next;
            r_cmd_ready <= (w_cmd_state_next == CMD_IDLE);
        end
    end

    // Command FSM: next state. A command accepted in a frame-start cycle
    // waits for the following frame, since that frame's load already happened.
    always_comb begin
        w_cmd_state_next = r_cmd_state;
        case (r_cmd_state)
            CMD_IDLE: begin
                if (w_cmd_accept) begin
                    w_cmd_state_next = CMD_PENDING;
                end
            end
            CMD_PENDING: begin
                if (w_frame_start) begin
                    w_cmd_state_next = CMD_SENT;
                end
            end
            CMD_SENT: begin
                if (w_frame_end) begin
                    w_cmd_state_next = CMD_IDLE;
                end
            end
            default: begin
                w_cmd_state_next = CMD_IDLE;
            end
        endcase
    end

    assign cmd_ready = r_cmd_ready;
    assign sync      = r_sync;
    assign sdata_out = r_sdata;
    assign new_frame = r_new_frame;
    assign underrun  = r_underrun;

endmodule
